// File: rtl/axi_uart_lite_if.sv
// axi_uart_lite_if: AXI4-Lite bundle between the Z80 bridge (master) and the UART (slave)
interface axi_uart_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_uart_lite.sv
// axi_uart_lite: AXI4-Lite UART with TX FIFO, 8N1 serializer/deserializer and status register
module axi_uart_lite #(
  parameter int CLK_DIV   = 868,
  parameter int FIFO_LOG2 = 4
) (
  input  logic           AXI_CLK,
  input  logic           RESETN,
  axi_uart_lite_if.slave axi,
  output logic           UART_TX,
  input  logic           UART_RX
);
  localparam logic [15:0] FULL_CNT = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_CNT = 16'(CLK_DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic        wr_hs, rd_hs, wr_en, push, stat_wr, data_rd;
  logic        bvalid_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  wr_addr, rd_addr;
  logic [6:0]  status;
  logic        unused;

  // Readies are combinational so the register side effect lands in the handshake cycle.
  assign wr_hs       = RESETN && axi.awvalid && axi.wvalid && !bvalid_q;
  assign rd_hs       = RESETN && axi.arvalid && !rvalid_q;
  assign axi.awready = wr_hs;
  assign axi.wready  = wr_hs;
  assign axi.arready = rd_hs;
  assign axi.bvalid  = bvalid_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.bresp   = 2'b00;
  assign axi.rresp   = 2'b00;
  assign wr_addr     = axi.awaddr[3:2];
  assign rd_addr     = axi.araddr[3:2];
  assign wr_en       = wr_hs && axi.wstrb[0];
  assign push        = wr_en && wr_addr == 2'd0;
  assign stat_wr     = wr_en && wr_addr == 2'd1;
  assign data_rd     = rd_hs && rd_addr == 2'd0;
  assign unused      = ^{axi.awaddr[31:4], axi.awaddr[1:0], axi.wdata[31:8], axi.wstrb[3:1],
                         axi.araddr[31:4], axi.araddr[1:0]};

  logic [7:0]       mem [2**FIFO_LOG2];
  logic [FIFO_LOG2:0] wp, rp;
  logic             tx_full, tx_empty, pop, tx_drop;

  assign tx_empty = wp == rp;
  assign tx_full  = (wp ^ rp) == {1'b1, {FIFO_LOG2{1'b0}}};

  always_ff @(posedge AXI_CLK)
    if (push && !tx_full) mem[wp[FIFO_LOG2-1:0]] <= axi.wdata[7:0];

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !tx_full) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end

  state_t      tx_st, tx_ns;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_q, tx_end;

  assign tx_end  = tx_cnt == 16'd0;
  assign UART_TX = tx_q;

  always_ff @(posedge AXI_CLK) tx_st <= RESETN ? tx_ns : IDLE;

  always_comb begin
    tx_ns = tx_st;
    pop   = 1'b0;
    unique case (tx_st)
      IDLE:  begin
        pop   = !tx_empty;
        tx_ns = tx_empty ? IDLE : START;
      end
      START: tx_ns = tx_end ? DATA : START;
      DATA:  tx_ns = tx_end && tx_bit == 3'd7 ? STOP : DATA;
      STOP:  begin
        pop   = tx_end && !tx_empty;
        tx_ns = !tx_end ? STOP : tx_empty ? IDLE : START;
      end
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      tx_q   <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (pop) begin
      tx_sh  <= mem[rp[FIFO_LOG2-1:0]];
      tx_q   <= 1'b0;
      tx_cnt <= FULL_CNT;
    end else if (tx_st != IDLE) begin
      tx_cnt <= tx_end ? FULL_CNT : tx_cnt - 16'd1;
      if (tx_end && tx_st == START) begin
        tx_q   <= tx_sh[0];
        tx_bit <= '0;
      end else if (tx_end && tx_st == DATA) begin
        tx_q   <= tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end else if (tx_end) begin
        tx_q <= 1'b1;
      end
    end
  end

  state_t      rx_st, rx_ns;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_data;
  logic        rx_s1, rx_s2, rx_prev, rx_end, rx_ok, rx_bad, rx_keep;
  logic        rx_valid, rx_ovr, rx_frm;

  assign rx_end  = rx_cnt == 16'd0;
  assign rx_ok   = rx_st == STOP && rx_end && rx_s2;
  assign rx_bad  = rx_st == STOP && rx_end && !rx_s2;
  assign rx_keep = rx_valid && !data_rd;

  always_ff @(posedge AXI_CLK) rx_st <= RESETN ? rx_ns : IDLE;

  always_comb begin
    rx_ns = rx_st;
    unique case (rx_st)
      IDLE:  rx_ns = rx_prev && !rx_s2 ? START : IDLE;
      START: rx_ns = !rx_end ? START : rx_s2 ? IDLE : DATA;
      DATA:  rx_ns = rx_end && rx_bit == 3'd7 ? STOP : DATA;
      STOP:  rx_ns = rx_end ? IDLE : STOP;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, UART_RX};
      rx_cnt <= rx_st == IDLE ? HALF_CNT : rx_end ? FULL_CNT : rx_cnt - 16'd1;
      if (rx_st == START) rx_bit <= '0;
      if (rx_st == DATA && rx_end) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end

  // A DATA read coinciding with a good stop bit frees the holding register for the new byte.
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_ovr   <= 1'b0;
      rx_frm   <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      rx_valid <= rx_ok || rx_keep;
      if (rx_ok && !rx_keep) rx_data <= rx_sh;
      rx_ovr  <= (rx_ovr && !(stat_wr && axi.wdata[4])) || (rx_ok && rx_keep);
      rx_frm  <= (rx_frm && !(stat_wr && axi.wdata[5])) || rx_bad;
      tx_drop <= (tx_drop && !(stat_wr && axi.wdata[6])) || (push && tx_full);
    end
  end

  assign status = {tx_drop, rx_frm, rx_ovr, rx_valid, !tx_empty || tx_st != IDLE, tx_empty, tx_full};

  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      bvalid_q <= wr_hs || (bvalid_q && !axi.bready);
      rvalid_q <= rd_hs || (rvalid_q && !axi.rready);
      if (rd_hs)
        rdata_q <= rd_addr == 2'd0 ? {24'b0, rx_data} : rd_addr == 2'd1 ? {25'b0, status} : 32'b0;
    end
  end
endmodule

// File: tb/tb_axi_uart_lite.sv
// tb_axi_uart_lite: directed bench with read-data and TX-frame scoreboards
module tb_axi_uart_lite;
  logic AXI_CLK = 1'b0;
  logic RESETN  = 1'b0;
  logic UART_RX = 1'b1;
  logic UART_TX;
  int   errors  = 0;
  int   checks  = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];

  axi_uart_lite_if axi ();

  axi_uart_lite #(.CLK_DIV(4), .FIFO_LOG2(2)) dut (
    .AXI_CLK(AXI_CLK),
    .RESETN (RESETN),
    .axi    (axi),
    .UART_TX(UART_TX),
    .UART_RX(UART_RX)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    axi.awaddr  = {28'b0, a};
    axi.wdata   = d;
    axi.wstrb   = s;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    #1 chk("wr_ready", 32'({axi.awready, axi.wready}), 32'h3);
    @(negedge AXI_CLK);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    chk("wr_bvalid", 32'({axi.bvalid, axi.bresp}), 32'h4);
    axi.bready = 1'b1;
    @(negedge AXI_CLK);
    axi.bready = 1'b0;
    chk("wr_bdone", 32'(axi.bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    axi.araddr  = {28'b0, a};
    axi.arvalid = 1'b1;
    #1 chk("rd_arready", 32'(axi.arready), 32'h1);
    @(negedge AXI_CLK);
    axi.arvalid = 1'b0;
    chk("rd_rvalid", 32'({axi.rvalid, axi.rresp}), 32'h4);
    chk($sformatf("rd_data_%0d", a), axi.rdata, rd_q.pop_front());
    axi.rready = 1'b1;
    @(negedge AXI_CLK);
    axi.rready = 1'b0;
    chk("rd_rdone", 32'(axi.rvalid), 32'h0);
  endtask

  // Samples every cycle of n back-to-back frames starting at the first low level.
  task automatic tx_mon(input int n);
    int k = 0;
    logic [9:0] obs;
    logic [3:0] smp;
    int bad;
    while (UART_TX !== 1'b0 && k < 8) begin
      @(negedge AXI_CLK);
      k++;
    end
    chk("tx_start_lat", 32'(k >= 1 && k <= 3), 32'h1);
    for (int f = 0; f < n; f++) begin
      bad = 0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 4; c++) begin
          smp[c] = UART_TX;
          @(negedge AXI_CLK);
        end
        obs[b] = smp[1];
        if (smp !== {4{smp[1]}}) bad++;
      end
      chk($sformatf("tx_frame_%0d", f), 32'(obs), 32'({1'b1, tx_q.pop_front(), 1'b0}));
      chk($sformatf("tx_width_%0d", f), 32'(bad), 32'h0);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic sb);
    logic [9:0] fr;
    fr = {sb, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      UART_RX = fr[b];
      repeat (4) @(negedge AXI_CLK);
    end
    UART_RX = 1'b1;
    repeat (8) @(negedge AXI_CLK);
  endtask

  initial begin
    int bad;
    {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} = 5'b11100;
    axi.awaddr = '0;
    axi.araddr = '0;
    axi.wdata  = 32'h12;
    axi.wstrb  = 4'hF;
    repeat (3) @(negedge AXI_CLK);
    chk("rst_handshake", 32'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 32'h0);
    chk("rst_rdata", axi.rdata, 32'h0);
    chk("rst_tx", 32'(UART_TX), 32'h1);
    {axi.awvalid, axi.wvalid, axi.arvalid} = 3'b000;
    RESETN = 1'b1;
    @(negedge AXI_CLK);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h0);
    axi_read(4'hC, 32'h0);
    chk("idle_tx", 32'(UART_TX), 32'h1);

    axi.awvalid = 1'b1;
    repeat (3) @(negedge AXI_CLK);
    chk("aw_only", 32'({axi.awready, axi.wready, axi.bvalid}), 32'h0);
    {axi.awvalid, axi.wvalid} = 2'b01;
    repeat (3) @(negedge AXI_CLK);
    chk("w_only", 32'({axi.awready, axi.wready, axi.bvalid}), 32'h0);
    axi.wvalid = 1'b0;

    axi_write(4'h0, 32'h77, 4'b1110);
    repeat (3) @(negedge AXI_CLK);
    chk("nostrb_tx", 32'(UART_TX), 32'h1);
    axi_read(4'h4, 32'h2);

    tx_q.push_back(8'h55);
    fork
      axi_write(4'h0, 32'h55, 4'hF);
      tx_mon(1);
    join
    repeat (3) @(negedge AXI_CLK);
    axi_read(4'h4, 32'h2);

    for (int v = 1; v <= 5; v++) tx_q.push_back(8'(v));
    fork
      for (int v = 1; v <= 6; v++) axi_write(4'h0, 32'(v), 4'hF);
      tx_mon(5);
    join
    repeat (3) @(negedge AXI_CLK);
    axi_read(4'h4, 32'h42);
    axi_write(4'h4, 32'h40, 4'hF);
    axi_read(4'h4, 32'h2);

    send_rx(8'hA3, 1'b1);
    axi_read(4'h4, 32'h0A);
    axi_read(4'h0, 32'hA3);
    axi_read(4'h4, 32'h02);

    send_rx(8'h3C, 1'b1);
    send_rx(8'hC5, 1'b1);
    axi_read(4'h4, 32'h1A);
    send_rx(8'h99, 1'b0);
    axi_read(4'h4, 32'h3A);
    axi_read(4'h0, 32'h3C);
    axi_read(4'h4, 32'h32);
    axi_write(4'h4, 32'h30, 4'hF);
    axi_read(4'h4, 32'h02);

    rd_q.push_back(32'h2);
    axi.awaddr  = 32'h8;
    axi.wdata   = 32'h0;
    axi.araddr  = 32'h4;
    {axi.awvalid, axi.wvalid, axi.arvalid} = 3'b111;
    @(negedge AXI_CLK);
    for (int i = 0; i < 10; i++) begin
      chk("hold_flags", 32'({axi.awready, axi.arready, axi.bvalid, axi.rvalid}), 32'h3);
      chk("hold_rdata", axi.rdata, rd_q[0]);
      @(negedge AXI_CLK);
    end
    chk("hold_pop", axi.rdata, rd_q.pop_front());
    {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} = 5'b00011;
    @(negedge AXI_CLK);
    chk("hold_done", 32'({axi.bvalid, axi.rvalid}), 32'h0);
    {axi.bready, axi.rready} = 2'b00;

    axi_write(4'h0, 32'h00, 4'hF);
    axi_write(4'h0, 32'h11, 4'hF);
    repeat (6) @(negedge AXI_CLK);
    chk("mid_tx_low", 32'(UART_TX), 32'h0);
    RESETN = 1'b0;
    @(negedge AXI_CLK);
    chk("mid_rst_tx", 32'(UART_TX), 32'h1);
    RESETN = 1'b1;
    repeat (2) @(negedge AXI_CLK);
    axi_read(4'h4, 32'h2);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (UART_TX !== 1'b1) bad++;
      @(negedge AXI_CLK);
    end
    chk("flushed_tx", 32'(bad), 32'h0);
    chk("sb_empty", 32'(rd_q.size() + tx_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
